window_delta_averager: RTL
==========================

// Module: window_delta_averager
// PURPOSE
//  Downstream consumer of the variable-delay shift register in the sensor pipeline.
//  Takes the live counter value and its delayed copy, and forms the windowed delta IN-DELAYED.
//  Averages that delta over 2^AVG_SHIFT valid samples and emits one result per window.
//  Suppresses output while the delay line refills after reset or after any DELAY change.
// PARAMETERS
//  DATA_BITS   32  width of IN_VALUE, DELAYED_VALUE, AVG_VALUE
//  DELAY_BITS  4   width of DELAY (same value drives the delay line)
//  AVG_SHIFT   3   samples per window = 2^AVG_SHIFT
//  PIPE_LAT    1   extra CE cycles of delay-line latency beyond DELAY
// PORTS
//  CLK            in   1           system clock, all logic on posedge
//  RESET          in   1           asynchronous, active-low reset
//  CE             in   1           clock enable; all state holds when 0
//  DELAY          in   DELAY_BITS  current delay-line setting
//  IN_VALUE       in   DATA_BITS   live sample (same bus that feeds the delay line)
//  DELAYED_VALUE  in   DATA_BITS   delay-line output
//  AVG_VALUE      out  DATA_BITS   window average of (IN_VALUE-DELAYED_VALUE)
//  AVG_VALID      out  1           one-CLK pulse when AVG_VALUE is updated
//  SETTLED        out  1           1 when the delay-line history matches DELAY
// BEHAVIOUR
//  Reset (RESET=0, asynchronous) applies immediately:
//   - AVG_VALUE=0, AVG_VALID=0, SETTLED=0, acc=0, cnt=0, diff_v=0, delay_q=0
//   - settle_cnt = 2^DELAY_BITS-1+PIPE_LAT (conservative full refill)
//  CE=0: no state changes; AVG_VALID=0 on that cycle.
//  Delay tracking (each CE cycle):
//   - DELAY!=delay_q: delay_q<=DELAY, settle_cnt<=DELAY+PIPE_LAT, acc<=0, cnt<=0, diff_v<=0.
//     The partial window is discarded and no AVG_VALID is produced for it.
//   - else if settle_cnt!=0: settle_cnt decrements.
//   - SETTLED = (settle_cnt==0), registered.
//   - A DELAY change while CE=0 is acted on at the next CE cycle.
//  Stage 1 (on CE):
//   - diff_r <= IN_VALUE-DELAYED_VALUE, modulo 2^DATA_BITS (unsigned wrap, no saturation).
//   - diff_v <= SETTLED & no DELAY change this cycle.
//  Stage 2 (on CE & diff_v):
//   - acc (DATA_BITS+AVG_SHIFT bits) <= acc+diff_r; cnt increments.
//   - When cnt==2^AVG_SHIFT-1 (last sample of the window):
//     AVG_VALUE <= (acc+diff_r)>>AVG_SHIFT, AVG_VALID<=1, acc<=0, cnt<=0.
//  Latency: the last sample's IN_VALUE is presented, then AVG_VALUE/AVG_VALID update 2 CE cycles later.
//  AVG_VALUE holds between pulses. Gaps in diff_v pause the window; they do not reset it.
//  Simultaneous DELAY change and window completion: the change wins, and no pulse is emitted.
// STRUCTURE
//  Shared sensor package holds:
//   - DATA_BITS/DELAY_BITS defaults, PIPE_LAT constant
//   - typedefs sample_t (DATA_BITS) and delay_t (DELAY_BITS)
//  One sub-module, delay_settle_tracker:
//   - inputs CLK/RESET/CE/DELAY
//   - outputs SETTLED and a one-cycle delay_changed strobe
//   - holds delay_q and settle_cnt
//  Diff, accumulator and window counter stay in the top module.
// TESTING
//  Bench drives IN_VALUE as a CE-gated ramp. A behavioural delay model supplies
//  DELAYED_VALUE = IN from DELAY+PIPE_LAT CE cycles earlier.
//  1 Reset: RESET=0 mid-window -> AVG_VALUE=0, AVG_VALID=0, SETTLED=0 at once, not at the next edge.
//  2 DELAY=5, CE=1 -> SETTLED low 6 CE cycles; AVG_VALID every 8 CLKs; AVG_VALUE=6.
//  3 DELAY 5->9 mid-window -> no pulse for the partial window; SETTLED low 10 CE cycles;
//    next AVG_VALUE=10.
//  4 Wrap: ramp starts at 32'hFFFF_FFFC, DELAY=5 -> AVG_VALUE=6 across the counter wrap.
//  5 CE alternating 1/0 -> AVG_VALID every 16 CLKs, never while CE=0; values identical to test 2.
//  6 DELAY=0 -> AVG_VALUE=1; DELAY=15 -> AVG_VALUE=16; change coinciding with the last sample -> no pulse.

Source files
------------

// File: rtl/window_delta_averager_pkg.sv
// Shared sensor-pipeline definitions: default widths, delay-line latency and
// the sample/delay types used by the windowed delta averager and its bench.
package window_delta_averager_pkg;

    localparam int DATA_BITS_DEF  = 32;
    localparam int DELAY_BITS_DEF = 4;
    localparam int AVG_SHIFT_DEF  = 3;

    // Extra CE cycles the delay line adds on top of its DELAY setting.
    localparam int PIPE_LAT_DEF   = 1;

    typedef logic [DATA_BITS_DEF-1:0]  sample_t;
    typedef logic [DELAY_BITS_DEF-1:0] delay_t;

endpackage

// File: rtl/window_delta_averager_delay_settle_tracker.sv
// Tracks the delay-line setting and reports when its history is consistent
// with DELAY again. A change restarts the refill countdown; reset assumes the
// worst case (the longest possible delay must refill).
module delay_settle_tracker
    import window_delta_averager_pkg::*;
#(
    parameter int DELAY_BITS = DELAY_BITS_DEF,
    parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CE,
    input  logic [DELAY_BITS-1:0] DELAY,
    output logic                  SETTLED,
    output logic                  delay_changed
);

    localparam int CNT_BITS = $clog2((2 ** DELAY_BITS) + PIPE_LAT);
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'((2 ** DELAY_BITS) - 1 + PIPE_LAT);

    logic [DELAY_BITS-1:0] delay_q;
    logic [DELAY_BITS-1:0] delay_d;
    logic [CNT_BITS-1:0]   settle_cnt_q;
    logic [CNT_BITS-1:0]   settle_cnt_d;
    logic                  settled_q;
    logic                  settled_d;

    // A change is only recognised on an enabled cycle; a change made while
    // CE is low is picked up by the next enabled cycle.
    assign delay_changed = CE && (DELAY != delay_q);

    // Reload the countdown on a change, otherwise count the refill down.
    always_comb begin
        delay_d      = delay_q;
        settle_cnt_d = settle_cnt_q;
        if (delay_changed) begin
            delay_d      = DELAY;
            settle_cnt_d = CNT_BITS'(DELAY) + CNT_BITS'(PIPE_LAT);
        end else if (CE && (settle_cnt_q != '0)) begin
            settle_cnt_d = settle_cnt_q - CNT_BITS'(1);
        end
        // Registered view of the new count, so SETTLED rises on the same
        // edge that takes the countdown to zero.
        settled_d = (settle_cnt_d == '0);
    end

    // Tracker state with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            delay_q      <= '0;
            settle_cnt_q <= CNT_FULL;
            settled_q    <= 1'b0;
        end else begin
            delay_q      <= delay_d;
            settle_cnt_q <= settle_cnt_d;
            settled_q    <= settled_d;
        end
    end

    assign SETTLED = settled_q;

endmodule

// File: rtl/window_delta_averager.sv
// Windowed delta averager: forms IN_VALUE-DELAYED_VALUE (modulo 2^DATA_BITS),
// averages it over 2^AVG_SHIFT accepted samples and emits one result per
// window. Samples are ignored while the delay line refills, and a DELAY
// change discards the partial window (it also wins over a window completing
// on the same cycle).
module window_delta_averager
    import window_delta_averager_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int DELAY_BITS = DELAY_BITS_DEF,
    parameter int AVG_SHIFT  = AVG_SHIFT_DEF,
    parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CE,
    input  logic [DELAY_BITS-1:0] DELAY,
    input  logic [DATA_BITS-1:0]  IN_VALUE,
    input  logic [DATA_BITS-1:0]  DELAYED_VALUE,
    output logic [DATA_BITS-1:0]  AVG_VALUE,
    output logic                  AVG_VALID,
    output logic                  SETTLED
);

    localparam int ACC_BITS = DATA_BITS + AVG_SHIFT;
    localparam logic [AVG_SHIFT-1:0] CNT_LAST = '1;

    // Window mean: plain truncating shift of the window sum.
    function automatic logic [DATA_BITS-1:0] window_mean(input logic [ACC_BITS-1:0] sum);
        return sum[ACC_BITS-1:AVG_SHIFT];
    endfunction

    logic                 settled;
    logic                 delay_changed;

    logic [DATA_BITS-1:0] diff_p1_q;
    logic [DATA_BITS-1:0] diff_p1_d;
    logic                 vld_p1_q;
    logic                 vld_p1_d;

    logic [ACC_BITS-1:0]  acc_p2_q;
    logic [ACC_BITS-1:0]  acc_p2_d;
    logic [AVG_SHIFT-1:0] cnt_p2_q;
    logic [AVG_SHIFT-1:0] cnt_p2_d;
    logic [DATA_BITS-1:0] avg_value_p2_q;
    logic [DATA_BITS-1:0] avg_value_p2_d;
    logic                 vld_p2_q;
    logic                 vld_p2_d;

    logic [ACC_BITS-1:0]  acc_sum;

    delay_settle_tracker #(
        .DELAY_BITS (DELAY_BITS),
        .PIPE_LAT   (PIPE_LAT)
    ) u_settle (
        .CLK           (CLK),
        .RESET         (RESET),
        .CE            (CE),
        .DELAY         (DELAY),
        .SETTLED       (settled),
        .delay_changed (delay_changed)
    );

    // Running sum including the sample currently leaving stage 1; the delta
    // is an unsigned modulo quantity, so it is zero-extended.
    assign acc_sum = acc_p2_q + ACC_BITS'(diff_p1_q);

    // Next-state logic for both pipeline stages.
    always_comb begin
        diff_p1_d      = diff_p1_q;
        vld_p1_d       = vld_p1_q;
        acc_p2_d       = acc_p2_q;
        cnt_p2_d       = cnt_p2_q;
        avg_value_p2_d = avg_value_p2_q;
        vld_p2_d       = 1'b0;

        if (CE) begin
            // Stage 0 -> 1: raw delta, qualified by the settle state.
            diff_p1_d = IN_VALUE - DELAYED_VALUE;

            if (delay_changed) begin
                vld_p1_d = 1'b0;
                acc_p2_d = '0;
                cnt_p2_d = '0;
            end else begin
                vld_p1_d = settled;

                // Stage 1 -> 2: accumulate and close the window on its last sample.
                if (vld_p1_q) begin
                    if (cnt_p2_q == CNT_LAST) begin
                        avg_value_p2_d = window_mean(acc_sum);
                        vld_p2_d       = 1'b1;
                        acc_p2_d       = '0;
                        cnt_p2_d       = '0;
                    end else begin
                        acc_p2_d = acc_sum;
                        cnt_p2_d = cnt_p2_q + AVG_SHIFT'(1);
                    end
                end
            end
        end
    end

    // Control and result state with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vld_p1_q       <= 1'b0;
            acc_p2_q       <= '0;
            cnt_p2_q       <= '0;
            avg_value_p2_q <= '0;
            vld_p2_q       <= 1'b0;
        end else begin
            vld_p1_q       <= vld_p1_d;
            acc_p2_q       <= acc_p2_d;
            cnt_p2_q       <= cnt_p2_d;
            avg_value_p2_q <= avg_value_p2_d;
            vld_p2_q       <= vld_p2_d;
        end
    end

    // Stage 1 delta register; meaningless until its valid is set, so no reset.
    always_ff @(posedge CLK) begin
        diff_p1_q <= diff_p1_d;
    end

    assign AVG_VALUE = avg_value_p2_q;
    assign AVG_VALID = vld_p2_q;
    assign SETTLED   = settled;

endmodule
